// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data in, downstream valid/ready/data out.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Side that drives the pipeline register (upstream producer + downstream consumer).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The pipeline register itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline register with a 2-entry skid buffer: registered in_ready, full
// throughput, FIFO ordering, synchronous flush. All outputs come from state.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           flush,
  pipe_skid_reg_if.slave bus,
  output logic [1:0]     occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready;
  logic             out_valid;
  logic             in_fire;
  logic             out_fire;

  assign in_ready      = (state_q != SKID);
  assign out_valid     = (state_q != EMPTY);
  assign in_fire       = bus.in_valid & in_ready;
  assign out_fire      = out_valid & bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;

  // Occupancy is a direct decode of the state.
  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and next-data logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = bus.in_data;
            state_d = FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            skid_d  = bus.in_data;
            state_d = SKID;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  a_occ_max: assert property (@(posedge Clk) disable iff (!Reset_n) occupancy <= 2'd2);
  a_no_fire_in_skid: assert property (@(posedge Clk) disable iff (!Reset_n)
    !(in_fire && state_q == SKID));
  a_state_legal: assert property (@(posedge Clk) disable iff (!Reset_n)
    state_q inside {EMPTY, FULL, SKID});

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_skid_reg;
  localparam int unsigned W  = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

  logic       Clk;
  logic       Reset_n;
  logic       flush;
  logic [1:0] occupancy;

  int vectors     = 0;
  int miscompares = 0;

  pipe_skid_reg_if #(.WIDTH(W)) bus ();

  pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a FIFO of at most two words plus the last value shown.
  logic [W-1:0] mq[$];
  logic [W-1:0] held;

  always @(posedge Clk or negedge Reset_n) begin
    logic mi_fire, mo_fire;
    if (!Reset_n) begin
      mq.delete();
      held = RV;
    end else begin
      mi_fire = bus.in_valid && (mq.size() < 2);
      mo_fire = (mq.size() > 0) && bus.out_ready;
      if (flush) begin
        mq.delete();
        held = RV;
      end else begin
        if (mo_fire) begin
          held = mq[0];
          void'(mq.pop_front());
        end
        if (mi_fire) mq.push_back(bus.in_data);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    chk("occupancy", {30'd0, occupancy}, mq.size());
    chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, mq.size() < 2});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    chk("out_data",  bus.out_data, (mq.size() > 0) ? mq[0] : held);
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs.
    Reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      #10;
    end
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_data", bus.out_data, RV);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge Clk);
    #2 Reset_n = 1'b1;
    tick(); tick();
    chk("post_rst_data", bus.out_data, RV);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    // Streaming: one word per cycle, shown one cycle later.
    for (int unsigned i = 1; i <= 16; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      tick();
      chk("stream_data", bus.out_data, i);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("stream_drain", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure into the skid entry.
    drive(1'b1, 32'hA, 1'b0, 1'b0); tick();
    chk("bp_occ1", {30'd0, occupancy}, 32'd1);
    drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
    chk("bp_occ2", {30'd0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold_a", bus.out_data, 32'hA);
    drive(1'b1, 32'hC, 1'b0, 1'b0); tick();
    chk("bp_still_a", bus.out_data, 32'hA);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("bp_out_b", bus.out_data, 32'hB);
    chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Flush while in SKID.
    drive(1'b1, 32'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    chk("fl_occ", {30'd0, occupancy}, 32'd0);
    chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("fl_data", bus.out_data, RV);

    // Flush with a simultaneous in_fire while FULL.
    drive(1'b1, 32'h55, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h33, 1'b0, 1'b1); tick();
    chk("fl_drop_occ", {30'd0, occupancy}, 32'd0);
    drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
    chk("fl_next_44", bus.out_data, 32'h44);
    drive(1'b0, '0, 1'b1, 1'b0); tick();
    chk("fl_44_held", bus.out_data, 32'h44);
    chk("fl_44_gone", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset while in SKID.
    drive(1'b1, 32'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h88, 1'b0, 1'b0); tick();
    #1 Reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_occ", {30'd0, occupancy}, 32'd0);
    chk("arst_data", bus.out_data, RV);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    Reset_n = 1'b1;
    tick(); tick();
    chk("arst_no_stale", bus.out_data, RV);
    chk("arst_no_valid", {31'd0, bus.out_valid}, 32'd0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
            $urandom_range(0, 31) == 0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick(); tick();

    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline register for the RISC-V datapath; successor to the single-bit enable flip-flop.
- Carries a WIDTH-bit payload between pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput with a registered in_ready.
- A synchronous flush discards in-flight contents on branch mispredict or trap.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VALUE, {WIDTH{1'b0}}, value loaded into both data registers on reset and on flush

Ports:
Clk  input  1  clock; all state changes on rising edge
Reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all contents
in_valid  input  1  upstream has data
in_ready  output  1  registered; block can accept data
in_data  input  WIDTH  upstream payload
out_valid  output  1  main register holds valid data
out_ready  input  1  downstream accepts data
out_data  output  WIDTH  main register contents
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset_n is asynchronous and active-low. While low:
  - state = EMPTY, in_ready = 1, out_valid = 0, occupancy = 0.
  - main_q = skid_q = RESET_VALUE.
  - Deassertion takes effect at the next Clk edge.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States:
  - EMPTY: occupancy 0.
  - FULL: main valid, occupancy 1.
  - SKID: main and skid valid, occupancy 2.
- Derived outputs, all from registered state only (no combinational in->out paths):
  - out_valid = (state != EMPTY).
  - in_ready = (state != SKID).
  - out_data = main_q.
- Transitions when flush = 0:
  - EMPTY, in_fire: main_q <= in_data, go to FULL.
  - EMPTY, no in_fire: hold.
  - FULL, in_fire & out_fire: main_q <= in_data, stay FULL.
  - FULL, in_fire only: skid_q <= in_data, go to SKID.
  - FULL, out_fire only: go to EMPTY; main_q holds its last value.
  - FULL, neither: hold.
  - SKID (in_fire impossible), out_fire: main_q <= skid_q, go to FULL.
  - SKID, no out_fire: hold.
- Ordering: data leaves in FIFO order; skid_q is always younger than main_q.
- Latency and throughput: 1 cycle from in_fire to out_valid; sustained 1 transfer/cycle while out_ready = 1.
- Data stability: out_data and out_valid must not change while out_valid = 1 and out_ready = 0. in_data is sampled only on in_fire.
- flush = 1 (priority over all transitions, below Reset_n):
  - Next state EMPTY; main_q, skid_q <= RESET_VALUE.
  - An in_fire in the same cycle completes the handshake, but its data is dropped.
  - An out_fire in the same cycle counts as consumed downstream.
  - in_ready = 1 and out_valid = 0 in the following cycle.
- Reset mid-operation: contents are lost immediately; outputs go to reset values asynchronously.
- Illegal-condition checks (simulation assertions):
  - occupancy never exceeds 2.
  - in_fire never occurs in SKID.
  - state encoding is never outside EMPTY/FULL/SKID.

Test Plan:
- Reset: hold Reset_n = 0 with random inputs -> in_ready = 1, out_valid = 0, occupancy = 0, out_data = RESET_VALUE; release -> unchanged until first in_fire.
- Streaming: out_ready = 1, send 0x1, 0x2, ... 0x10 on consecutive cycles -> out_data equals each value exactly 1 cycle later; occupancy stays at 1; no bubbles.
- Backpressure/skid: send 0xA then 0xB with out_ready = 0:
  - occupancy goes 1 then 2; in_ready = 0; out_data holds 0xA.
  - Raise out_ready -> 0xA, then 0xB, then out_valid = 0; in_ready returns to 1 one cycle after the first out_fire.
- Flush in SKID: fill with 0x11, 0x22, assert flush for one cycle -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, out_data = RESET_VALUE; 0x11 and 0x22 never appear on the output.
- Flush with simultaneous in_fire in FULL: in_data = 0x33 with flush = 1 -> 0x33 is dropped; the next accepted word, 0x44, emerges first.
- Async reset mid-stream: drop Reset_n between clock edges while in SKID -> out_valid falls before the next edge; no stale data appears after release.
